inputc_rx: RTL

- Receive end of the router-to-router physical channel; the per-port input channel of the downstream router.
- Accepts flits from the upstream output channel (data/valid/VC id) and buffers them in per-VC FIFOs.
- Presents each VC's head flit to the switch allocator/crossbar.
- Returns one credit ack per dequeued flit and a per-VC lock status to the upstream output channel.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/vc_fifo.sv | 56 +++++
 rtl/inputc_rx.sv | 78 +++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared router channel definitions used by both ends of a physical link.
// The flit type sits in the two most significant bits of each flit.
package noc_pkg;

    localparam int DATAW    = 35;
    localparam int NVCH     = 2;
    localparam int FIFOD    = 4;
    localparam int TYPE_MSB = DATAW - 1;
    localparam int TYPE_LSB = DATAW - 2;
    localparam int VCHW     = (NVCH > 1) ? $clog2(NVCH) : 1;
    localparam int CNTW     = $clog2(FIFOD) + 1;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'b00,
        FLIT_BODY     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    function automatic logic is_tail(flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC circular flit buffer. A write into a full FIFO is still accepted
// when a pop frees a slot in the same cycle; otherwise it is dropped.
module vc_fifo
    import noc_pkg::*;
#(
    parameter int DATAW    = noc_pkg::DATAW,
    parameter int FIFOD    = noc_pkg::FIFOD,
    parameter int TYPE_MSB = DATAW - 1,
    localparam int PTRW    = $clog2(FIFOD),
    localparam int CW      = PTRW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             valid,
    output logic             accepted,
    output logic             popped,
    output logic             ovf,
    output flit_type_e       head_type
);

    logic [DATAW-1:0] mem [FIFOD];
    logic [PTRW-1:0]  wrptr;
    logic [PTRW-1:0]  rdptr;

    assign popped   = pop && (count != '0);
    assign accepted = push && ((count != CW'(FIFOD)) || popped);
    assign ovf      = push && !accepted;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
        end else begin
            if (accepted) wrptr <= wrptr + 1'b1;
            if (popped)   rdptr <= rdptr + 1'b1;
            if (accepted && !popped)      count <= count + 1'b1;
            else if (!accepted && popped) count <= count - 1'b1;
        end
    end

    // Storage is never reset; stale slots are hidden behind count.
    always_ff @(posedge clk) begin
        if (accepted) mem[wrptr] <= wdata;
    end

    assign rdata     = mem[rdptr];
    assign valid     = (count != '0);
    assign head_type = flit_type_e'(rdata[TYPE_MSB -: 2]);

endmodule

// File: rtl/inputc_rx.sv
// Receive side of a router-to-router channel: per-VC buffering, head flit
// presentation to the allocator, and credit/lock feedback to the sender.
module inputc_rx
    import noc_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int DATAW    = noc_pkg::DATAW,
    parameter int NVCH     = noc_pkg::NVCH,
    parameter int FIFOD    = noc_pkg::FIFOD,
    localparam int VW      = (NVCH > 1) ? $clog2(NVCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATAW-1:0]      idata,
    input  logic                  ivalid,
    input  logic [VW-1:0]         ivch,
    input  logic [NVCH-1:0]       ideq,
    output logic [NVCH*DATAW-1:0] odata,
    output logic [NVCH-1:0]       ovalid,
    output logic [NVCH-1:0]       oack,
    output logic [NVCH-1:0]       olck,
    output logic                  ovf_err
);

    localparam int CW = $clog2(FIFOD) + 1;

    logic [CW-1:0] cnt [NVCH];
    flit_type_e    htype [NVCH];
    logic [NVCH-1:0] acc;
    logic [NVCH-1:0] pop;
    logic [NVCH-1:0] ovf;

    for (genvar g = 0; g < NVCH; g++) begin : g_vc
        vc_fifo #(
            .DATAW   (DATAW),
            .FIFOD   (FIFOD),
            .TYPE_MSB(DATAW - 1)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (ivalid && (ivch == VW'(g))),
            .pop      (ideq[g]),
            .wdata    (idata),
            .rdata    (odata[g*DATAW +: DATAW]),
            .count    (cnt[g]),
            .valid    (ovalid[g]),
            .accepted (acc[g]),
            .popped   (pop[g]),
            .ovf      (ovf[g]),
            .head_type(htype[g])
        );
    end

    // The lock drops only when the packet's tail leaves an otherwise empty VC;
    // a new write in the same cycle keeps it held.
    always_ff @(posedge clk) begin
        if (rst) begin
            oack    <= '0;
            olck    <= '0;
            ovf_err <= 1'b0;
        end else begin
            oack <= pop;
            for (int v = 0; v < NVCH; v++) begin
                if (acc[v])
                    olck[v] <= 1'b1;
                else if (pop[v] && is_tail(htype[v]) && (cnt[v] == CW'(1)))
                    olck[v] <= 1'b0;
            end
            if (|ovf) ovf_err <= 1'b1;
        end
    end

    a_vch_range: assert property (@(posedge clk) disable iff (rst)
        ivalid |-> (int'(ivch) < NVCH))
        else $error("router %0d pch %0d: ivch out of range", ROUTERID, PCHID);

endmodule
